// File: rtl/debounce_pkg.sv
`default_nettype none
// ============================================================================
// Module      : debounce_pkg
// Description : Shared defaults, repeat-state encoding and width helper for
//               the button conditioner.
// Revision    : 1.0
// ============================================================================
package debounce_pkg;

  localparam int DEBOUNCE_TIME_DEF = 100;
  localparam int REPEAT_DELAY_DEF  = 5000000;
  localparam int REPEAT_PERIOD_DEF = 1000000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } rpt_state_t;

  // Bits needed to hold values 0..max_val.
  function automatic int width_for(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/debounce_ch.sv
`default_nettype none
// ============================================================================
// Module      : debounce_ch
// Description : One button channel: synchroniser, debounce, edge pulses and
//               auto-repeat pulse generator.
// Revision    : 1.0
// ============================================================================
module debounce_ch
  import debounce_pkg::*;
#(
  parameter int DEBOUNCE_TIME = DEBOUNCE_TIME_DEF,
  parameter int CNT_W         = 17,
  parameter int REPEAT_DELAY  = REPEAT_DELAY_DEF,
  parameter int REPEAT_PERIOD = REPEAT_PERIOD_DEF,
  parameter int RPT_W         = 24
) (
  input  logic clk,
  input  logic rst,
  input  logic i_btn,
  input  logic i_rpt_en,
  output logic o_out,
  output logic o_rise,
  output logic o_fall,
  output logic o_rpt
);

  localparam logic [CNT_W-1:0] c_DB_TC = CNT_W'(DEBOUNCE_TIME - 1);
  localparam logic [RPT_W-1:0] c_RD_TC = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] c_RP_TC = RPT_W'(REPEAT_PERIOD - 1);

  logic             r_sync0;
  logic             r_sync1;
  logic [CNT_W-1:0] r_cnt;
  logic             r_out;
  logic             r_rise;
  logic             r_fall;
  logic             r_rpt;
  rpt_state_t       r_state;
  logic [RPT_W-1:0] r_rcnt;

  logic w_differ;
  logic w_commit;
  logic w_rise_c;
  logic w_fall_c;

  assign w_differ = (r_sync1 != r_out);
  assign w_commit = w_differ && (r_cnt == c_DB_TC);
  assign w_rise_c = w_commit &&  r_sync1;
  assign w_fall_c = w_commit && !r_sync1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync0 <= 1'b0;
      r_sync1 <= 1'b0;
      r_cnt   <= '0;
      r_out   <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
      r_rpt   <= 1'b0;
      r_state <= IDLE;
      r_rcnt  <= '0;
    end else begin
      r_sync0 <= i_btn;
      r_sync1 <= r_sync0;
      r_rise  <= w_rise_c;
      r_fall  <= w_fall_c;
      r_rpt   <= 1'b0;

      if (!w_differ) begin
        r_cnt <= '0;
      end else if (w_commit) begin
        r_out <= r_sync1;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end

      // A fall commit or dropped enable cancels before any terminal count.
      case (r_state)
        IDLE: begin
          if (w_rise_c) begin
            r_rpt   <= 1'b1;
            r_rcnt  <= '0;
            r_state <= i_rpt_en ? DELAY : IDLE;
          end
        end
        DELAY: begin
          if (w_fall_c || !i_rpt_en) begin
            r_state <= IDLE;
            r_rcnt  <= '0;
          end else if (r_rcnt == c_RD_TC) begin
            r_rpt   <= 1'b1;
            r_rcnt  <= '0;
            r_state <= REPEAT;
          end else begin
            r_rcnt  <= r_rcnt + RPT_W'(1);
          end
        end
        REPEAT: begin
          if (w_fall_c || !i_rpt_en) begin
            r_state <= IDLE;
            r_rcnt  <= '0;
          end else if (r_rcnt == c_RP_TC) begin
            r_rpt   <= 1'b1;
            r_rcnt  <= '0;
          end else begin
            r_rcnt  <= r_rcnt + RPT_W'(1);
          end
        end
        default: begin
          r_state <= IDLE;
          r_rcnt  <= '0;
        end
      endcase
    end
  end

  assign o_out  = r_out;
  assign o_rise = r_rise;
  assign o_fall = r_fall;
  assign o_rpt  = r_rpt;

endmodule
`default_nettype wire

// File: rtl/debounce_multi.sv
`default_nettype none
// ============================================================================
// Module      : debounce_multi
// Description : N independent button conditioners for the game controls.
// Revision    : 1.0
// ============================================================================
module debounce_multi
  import debounce_pkg::*;
#(
  parameter int N_CH          = 4,
  parameter int DEBOUNCE_TIME = DEBOUNCE_TIME_DEF,
  parameter int CNT_W         = 17,
  parameter int REPEAT_DELAY  = REPEAT_DELAY_DEF,
  parameter int REPEAT_PERIOD = REPEAT_PERIOD_DEF,
  parameter int RPT_W         = 24
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [N_CH-1:0] btn_in,
  input  logic [N_CH-1:0] rpt_en,
  output logic [N_CH-1:0] btn_out,
  output logic [N_CH-1:0] btn_rise,
  output logic [N_CH-1:0] btn_fall,
  output logic [N_CH-1:0] btn_rpt
);

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    debounce_ch #(
      .DEBOUNCE_TIME (DEBOUNCE_TIME),
      .CNT_W         (CNT_W),
      .REPEAT_DELAY  (REPEAT_DELAY),
      .REPEAT_PERIOD (REPEAT_PERIOD),
      .RPT_W         (RPT_W)
    ) u_ch (
      .clk      (CLK),
      .rst      (RST),
      .i_btn    (btn_in[g]),
      .i_rpt_en (rpt_en[g]),
      .o_out    (btn_out[g]),
      .o_rise   (btn_rise[g]),
      .o_fall   (btn_fall[g]),
      .o_rpt    (btn_rpt[g])
    );
  end

endmodule
`default_nettype wire

// File: tb/tb_debounce_multi.sv
`default_nettype none
// ============================================================================
// Module      : tb_debounce_multi
// Description : Directed stimulus with a behavioural reference model.
// Revision    : 1.0
// ============================================================================
module tb_debounce_multi;

  localparam int N  = 4;
  localparam int DT = 4;
  localparam int RD = 10;
  localparam int RP = 3;

  bit           CLK = 1'b0;
  logic         RST;
  logic [N-1:0] btn_in;
  logic [N-1:0] rpt_en;
  logic [N-1:0] btn_out;
  logic [N-1:0] btn_rise;
  logic [N-1:0] btn_fall;
  logic [N-1:0] btn_rpt;

  int n_chk  = 0;
  int n_fail = 0;
  bit cmp_en = 1'b0;

  debounce_multi #(
    .N_CH          (N),
    .DEBOUNCE_TIME (DT),
    .CNT_W         (17),
    .REPEAT_DELAY  (RD),
    .REPEAT_PERIOD (RP),
    .RPT_W         (24)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .btn_in   (btn_in),
    .rpt_en   (rpt_en),
    .btn_out  (btn_out),
    .btn_rise (btn_rise),
    .btn_fall (btn_fall),
    .btn_rpt  (btn_rpt)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  task automatic step(input int k);
    repeat (k) @(negedge CLK);
  endtask

  // Reference model: the synchronised input is btn_in delayed two edges; the
  // level commits after DT consecutive disagreeing samples; repeat pulses fall
  // on rise time R, R+RD, R+RD+RP, ... while the repeat stays alive.
  int           edge_n = 0;
  int           run    [N];
  int           rise_t [N];
  logic [N-1:0] dl0, dl1, m_out, e_rise, e_fall, e_rpt, alive;

  always @(posedge CLK) begin
    logic y;
    int   k;
    edge_n++;
    for (int c = 0; c < N; c++) begin
      if (RST) begin
        dl0[c] = 1'b0; dl1[c] = 1'b0; m_out[c] = 1'b0; run[c] = 0;
        e_rise[c] = 1'b0; e_fall[c] = 1'b0; e_rpt[c] = 1'b0; alive[c] = 1'b0;
        rise_t[c] = 0;
      end else begin
        y = dl1[c];
        dl1[c] = dl0[c];
        dl0[c] = btn_in[c];
        e_rise[c] = 1'b0;
        e_fall[c] = 1'b0;
        if (y != m_out[c]) begin
          run[c]++;
          if (run[c] == DT) begin
            e_rise[c] = y;
            e_fall[c] = !y;
            m_out[c]  = y;
            run[c]    = 0;
          end
        end else begin
          run[c] = 0;
        end
        if (e_rise[c]) begin
          rise_t[c] = edge_n;
          alive[c]  = rpt_en[c];
          e_rpt[c]  = 1'b1;
        end else begin
          if (e_fall[c] || !rpt_en[c]) alive[c] = 1'b0;
          k = edge_n - rise_t[c];
          e_rpt[c] = alive[c] && (k >= RD) && (((k - RD) % RP) == 0);
        end
      end
    end
  end

  always @(negedge CLK) begin
    if (cmp_en) begin
      chk("model_btn_out",  btn_out,  m_out);
      chk("model_btn_rise", btn_rise, e_rise);
      chk("model_btn_fall", btn_fall, e_fall);
      chk("model_btn_rpt",  btn_rpt,  e_rpt);
    end
  end

  bit bounce [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

  initial begin
    RST    = 1'b1;
    btn_in = '0;
    rpt_en = '0;
    cmp_en = 1'b1;
    step(2);
    chk("reset_out",  btn_out,  4'b0000);
    chk("reset_rise", btn_rise, 4'b0000);
    chk("reset_fall", btn_fall, 4'b0000);
    chk("reset_rpt",  btn_rpt,  4'b0000);
    RST = 1'b0;

    // Clean press on ch0
    btn_in[0] = 1'b1;
    step(5);
    chk("press_edge5_out", btn_out, 4'b0000);
    step(1);
    chk("press_edge6_out",  btn_out,  4'b0001);
    chk("press_edge6_rise", btn_rise, 4'b0001);
    chk("press_edge6_rpt",  btn_rpt,  4'b0001);
    step(1);
    chk("press_edge7_rise", btn_rise, 4'b0000);
    chk("press_edge7_rpt",  btn_rpt,  4'b0000);

    // Bounce rejection on ch1
    for (int i = 0; i < 8; i++) begin
      btn_in[1] = bounce[i];
      step(1);
    end
    btn_in[1] = 1'b1;
    step(5);
    chk("bounce_out_held", btn_out, 4'b0001);
    step(1);
    chk("bounce_rise", btn_rise, 4'b0010);

    // Auto-repeat on ch2
    rpt_en[2] = 1'b1;
    btn_in[2] = 1'b1;
    step(6);
    chk("rpt_R",    btn_rpt, 4'b0100);
    step(9);
    chk("rpt_R9",   btn_rpt, 4'b0000);
    step(1);
    chk("rpt_R10",  btn_rpt, 4'b0100);
    step(3);
    chk("rpt_R13",  btn_rpt, 4'b0100);
    step(21);
    btn_in[2] = 1'b0;
    step(5);
    chk("release_edge5_fall", btn_fall, 4'b0000);
    step(1);
    chk("release_edge6_fall", btn_fall, 4'b0100);
    rpt_en[2] = 1'b0;
    step(4);

    // Repeat disabled mid-hold on ch3
    rpt_en[3] = 1'b1;
    btn_in[3] = 1'b1;
    step(16);
    chk("dis_R10", btn_rpt, 4'b1000);
    rpt_en[3] = 1'b0;
    step(3);
    chk("dis_R13", btn_rpt, 4'b0000);
    step(3);
    rpt_en[3] = 1'b1;
    step(10);
    btn_in[3] = 1'b0;
    step(8);
    rpt_en[3] = 1'b0;

    // Reset while ch0 and ch1 are held
    RST = 1'b1;
    step(1);
    chk("midrst_out",  btn_out,  4'b0000);
    chk("midrst_rise", btn_rise, 4'b0000);
    chk("midrst_fall", btn_fall, 4'b0000);
    chk("midrst_rpt",  btn_rpt,  4'b0000);
    RST = 1'b0;
    step(5);
    chk("postrst_edge5_out", btn_out, 4'b0000);
    step(1);
    chk("postrst_edge6_out",  btn_out,  4'b0011);
    chk("postrst_edge6_rise", btn_rise, 4'b0011);
    step(1);
    chk("postrst_fall", btn_fall, 4'b0000);

    // Simultaneous press, ch1 repeating, ch0 released during repeats
    btn_in = '0;
    step(10);
    rpt_en = 4'b0010;
    btn_in = 4'b1111;
    step(6);
    chk("simul_rise", btn_rise, 4'b1111);
    step(4);
    btn_in[0] = 1'b0;
    step(6);
    chk("simul_R10_rpt",  btn_rpt,  4'b0010);
    chk("simul_R10_fall", btn_fall, 4'b0001);
    step(3);
    chk("simul_R13_rpt", btn_rpt, 4'b0010);
    step(10);
    btn_in = '0;
    rpt_en = '0;
    step(12);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/debounce_multi.md
Name: debounce_multi

Overview:
- Parametrised N-channel button conditioner for the Breakout controls (paddle left/right, launch, pause).
- Per channel it provides:
  - a 2-flop synchroniser;
  - a debounce counter;
  - a stable level output;
  - single-cycle rise and fall pulses;
  - an optional auto-repeat pulse train for held buttons, used for continuous paddle movement.
- Sits between the board button pins and the game FSM / paddle logic.

Parameters:
- N_CH, 4, number of independent button channels.
- DEBOUNCE_TIME, 100, consecutive cycles the synchronised input must differ from btn_out before btn_out commits; legal range 1..2^CNT_W-1.
- CNT_W, 17, debounce counter width.
- REPEAT_DELAY, 5000000, cycles from the rise pulse to the first repeat pulse; must be >= 1.
- REPEAT_PERIOD, 1000000, cycles between subsequent repeat pulses; must be >= 1.
- RPT_W, 24, repeat counter width; must hold max(REPEAT_DELAY, REPEAT_PERIOD)-1.

Ports:
- CLK  in  1  system clock.
- RST  in  1  synchronous, active-high reset.
- btn_in  in  N_CH  raw asynchronous button levels, 1 = pressed.
- rpt_en  in  N_CH  per-channel auto-repeat enable, sampled every cycle.
- btn_out  out  N_CH  debounced level.
- btn_rise  out  N_CH  1-cycle pulse on a btn_out 0->1 transition.
- btn_fall  out  N_CH  1-cycle pulse on a btn_out 1->0 transition.
- btn_rpt  out  N_CH  press/repeat pulse stream, 1 cycle per pulse.

Behaviour:
- Reset: on RST=1 at a rising edge of CLK, all of the following clear to 0 for every channel:
  - sync flops, debounce counter, repeat counter, repeat state (IDLE);
  - btn_out, btn_rise, btn_fall, btn_rpt.
- Reset dominates all other activity.
- Channels are fully independent; no shared state.
- Synchroniser: sync0 <= btn_in[i]; sync1 <= sync0.
- Debounce, evaluated each edge:
  - If sync1 == btn_out: cnt <= 0.
  - Else if cnt == DEBOUNCE_TIME-1: btn_out <= sync1, cnt <= 0.
  - Else: cnt <= cnt+1.
- A bounce shorter than DEBOUNCE_TIME cycles returns cnt to 0, and btn_out does not change.
- Latency: with edge 1 defined as the first edge sampling the new btn_in level, btn_out changes at edge DEBOUNCE_TIME+2 (input held stable throughout).
- Edge pulses are registered and asserted on the same edge that btn_out changes:
  - btn_rise = 1 for exactly one cycle on a 0->1 commit.
  - btn_fall = 1 for exactly one cycle on a 1->0 commit.
  - They are never simultaneous on one channel.
- Repeat FSM per channel, states IDLE, DELAY, REPEAT:
  - IDLE: on a rise commit, btn_rpt pulses (same edge as btn_rise), rcnt <= 0, and the FSM goes to DELAY if rpt_en=1, otherwise stays in IDLE.
  - DELAY: rcnt increments each cycle. When rcnt == REPEAT_DELAY-1: btn_rpt pulses, rcnt <= 0, go to REPEAT.
  - REPEAT: when rcnt == REPEAT_PERIOD-1: btn_rpt pulses, rcnt <= 0; otherwise rcnt increments.
  - A fall commit, or rpt_en=0 in DELAY/REPEAT, sends the FSM to IDLE with rcnt <= 0 on that edge, with no pulse.
  - A fall commit takes priority over a coincident repeat terminal count.
- Resulting repeat timing while rpt_en=1 and the button is held:
  - first repeat pulse REPEAT_DELAY cycles after btn_rise;
  - then one pulse every REPEAT_PERIOD cycles.
- Re-asserting rpt_en during a hold does not restart repeats; the next press is required.
- Reset mid-operation with a button held:
  - all outputs are 0 on the edge after RST;
  - after RST deasserts, btn_out and btn_rise follow at edge DEBOUNCE_TIME+2, counted from the first non-reset edge.
- Counters never wrap, because terminal counts always reload to 0.

Decomposition:
- Shared package debounce_pkg holds:
  - default constants: DEBOUNCE_TIME_DEF, REPEAT_DELAY_DEF, REPEAT_PERIOD_DEF;
  - the repeat-state enum: IDLE=2'd0, DELAY=2'd1, REPEAT=2'd2;
  - a clog2-based width helper for CNT_W/RPT_W sizing.
- One sub-module, debounce_ch, contains a single channel (synchroniser, debounce, edge pulses, repeat FSM).
- debounce_multi instantiates N_CH copies of debounce_ch in a generate loop.

Test Plan:
- Bench parameters: N_CH=4, DEBOUNCE_TIME=4, REPEAT_DELAY=10, REPEAT_PERIOD=3.
- Clean press: ch0 btn_in 0->1, held -> btn_out[0]=1 and btn_rise[0]=btn_rpt[0]=1 at edge 6, each for exactly 1 cycle; other channels remain 0.
- Bounce rejection: ch1 toggled 1,1,1,0,1,1,1,0 per cycle -> btn_out[1] stays 0 with no pulses. After stable 1 for 6 edges, btn_rise[1] fires once.
- Auto-repeat: ch2 rpt_en=1, held 40 cycles -> btn_rpt pulses at rise edge R, then R+10, R+13, R+16, ... Release -> btn_fall 1 pulse at release edge 6; no further btn_rpt.
- Repeat disable mid-hold: ch3 held, rpt_en dropped at R+11 -> no btn_rpt after R+10. Re-raising rpt_en -> still none until a new press.
- Reset mid-hold: ch0 held with btn_out=1, RST pulsed 1 cycle -> all outputs 0 on the next cycle. After RST deasserts: btn_out=1 and btn_rise pulse at edge 6; no btn_fall is ever generated by the reset.
- Simultaneous: all 4 channels pressed on the same cycle -> 4 independent rise pulses on the same edge; releasing ch0 while ch1 repeats leaves ch1 timing unaffected.
